// File: rtl/gpio_int_if.sv
// Register-file side of the GPIO interrupt detector: configuration in,
// synchronized pin state, pending flags and interrupt request out.
interface gpio_int_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] rf_gpio_tristate;
    logic [WIDTH-1:0] rf_gpio_interrupt_mask;
    logic             int_clr;
    logic [WIDTH-1:0] int_clr_bits;
    logic [WIDTH-1:0] ro_gpio_pinstate;
    logic [WIDTH-1:0] int_pending;
    logic             irq;

    modport master (
        output rf_gpio_tristate,
        output rf_gpio_interrupt_mask,
        output int_clr,
        output int_clr_bits,
        input  ro_gpio_pinstate,
        input  int_pending,
        input  irq
    );

    modport slave (
        input  rf_gpio_tristate,
        input  rf_gpio_interrupt_mask,
        input  int_clr,
        input  int_clr_bits,
        output ro_gpio_pinstate,
        output int_pending,
        output irq
    );
endinterface

// File: rtl/gpio_int_detect.sv
// GPIO pin synchronizer and any-edge interrupt detector with sticky
// per-pin pending flags and a registered interrupt request.
//
// state      | meaning
// RESET_HOLD | reset asserted; detection disabled
// WARMUP     | synchronizer filling; warm_cnt counts down to 0
// ARMED      | qualified edges set pending bits (terminal until reset)
module gpio_int_detect #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_pin_in,
    gpio_int_if.slave        bus
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        RESET_HOLD,
        WARMUP,
        ARMED
    } arm_state_t;

    arm_state_t                        state;
    logic [CNT_W-1:0]                  warm_cnt;
    logic                              armed;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  pin_sync;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  edge_raw;
    logic [WIDTH-1:0]                  qedge;
    logic [WIDTH-1:0]                  clr_sel;
    logic [WIDTH-1:0]                  pending_q;
    logic                              irq_q;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("gpio_int_detect: SYNC_STAGES must be at least 2");
        end
    endgenerate

    // sync_q[0] takes the raw pad level; the last stage is the usable value
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_pin_in};
        end
    end

    assign pin_sync = sync_q[SYNC_STAGES-1];
    assign edge_raw = pin_sync ^ prev_q;
    assign qedge    = armed ? (edge_raw & bus.rf_gpio_tristate & bus.rf_gpio_interrupt_mask)
                            : '0;
    assign clr_sel  = bus.int_clr ? bus.int_clr_bits : '0;

    // Set is OR-ed in after the clear so a simultaneous set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            prev_q    <= pin_sync;
            pending_q <= (pending_q & ~clr_sel) | qedge;
            irq_q     <= |(pending_q & bus.rf_gpio_interrupt_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RESET_HOLD;
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            case (state)
                RESET_HOLD: begin
                    state    <= WARMUP;
                    warm_cnt <= CNT_W'(SYNC_STAGES);
                    armed    <= 1'b0;
                end
                WARMUP: begin
                    if (warm_cnt == '0) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt - CNT_W'(1);
                    end
                end
                ARMED: begin
                    armed <= 1'b1;
                end
                default: begin
                    state    <= RESET_HOLD;
                    warm_cnt <= '0;
                    armed    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ro_gpio_pinstate = pin_sync;
    assign bus.int_pending      = pending_q;
    assign bus.irq              = irq_q;

endmodule
